// File: rtl/multicycle_mem_if.sv
// Request/response handshake bundle between the multicycle core (master) and its
// memory responder (slave).
interface multicycle_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    input  req_ready,
    output req_we,
    output req_addr,
    output req_wdata,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output rsp_valid,
    input  rsp_ready,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/multicycle_mem.sv
// Single-port word memory responder: one request at a time, access after a fixed
// LATENCY edges, result held on the response handshake until accepted.
module multicycle_mem #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_mem_if.slave   bus
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [Depth];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       addr_hi;
  logic              acc_err;
  logic              mem_we;

  assign idx     = addr_q[ADDR_W+1:2];
  assign addr_hi = addr_q >> (ADDR_W + 2);
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_hi != 32'd0);

  // State register plus latched request and response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx] <= wdata_q;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'd0 : mem_q[idx];
          mem_we  = we_q && !acc_err;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs depend on state alone.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_multicycle_mem.sv
// Directed bench: instance A (LATENCY=2) covers the main protocol, instance B
// (LATENCY=3) covers reset in the middle of a transaction.
module tb_multicycle_mem;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  multicycle_mem_if bus_a ();
  multicycle_mem_if bus_b ();

  multicycle_mem #(.ADDR_W(8), .LATENCY(2)) u_dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  multicycle_mem #(.ADDR_W(8), .LATENCY(3)) u_dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  // Shared stimulus steered to one instance; observation muxed back from it.
  logic        sel;
  logic        v_valid, v_we, v_rsp_ready;
  logic [31:0] v_addr, v_wdata;

  assign bus_a.req_valid = v_valid & ~sel;
  assign bus_b.req_valid = v_valid & sel;
  assign bus_a.req_we    = v_we;
  assign bus_b.req_we    = v_we;
  assign bus_a.req_addr  = v_addr;
  assign bus_b.req_addr  = v_addr;
  assign bus_a.req_wdata = v_wdata;
  assign bus_b.req_wdata = v_wdata;
  assign bus_a.rsp_ready = v_rsp_ready;
  assign bus_b.rsp_ready = v_rsp_ready;

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  assign o_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  assign o_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign o_rsp_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
  assign o_rsp_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE with rsp_ready high; returns response and edges to rsp_valid.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    v_valid = 1'b1; v_we = we; v_addr = addr; v_wdata = wdata; v_rsp_ready = 1'b1;
    step();
    v_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    step();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    sel = 1'b0; v_valid = 1'b0; v_we = 1'b0; v_addr = '0; v_wdata = '0; v_rsp_ready = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;

    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rdata", o_rsp_rdata, 32'd0);
    chk("rst_err", 32'(o_rsp_err), 32'd0);

    // Write then read, LATENCY=2
    xact(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_idle_after", 32'(o_req_ready), 32'd1);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Backpressure: response held for 5 cycles
    v_valid = 1'b1; v_we = 1'b0; v_addr = 32'h10; v_rsp_ready = 1'b0;
    step();
    v_valid = 1'b0;
    chk("bp_wait_ready", 32'(o_req_ready), 32'd0);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_rdata", o_rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
      step();
    end
    v_rsp_ready = 1'b1;
    step();
    chk("bp_idle_ready", 32'(o_req_ready), 32'd1);
    chk("bp_idle_valid", 32'(o_rsp_valid), 32'd0);

    // Error cases: 0x11 aliases word 4, 0x400 aliases word 0
    xact(1'b1, 32'h0, 32'h11111111, rd, er, lat);
    xact(1'b1, 32'h100, 32'h22222222, rd, er, lat);
    xact(1'b1, 32'h11, 32'h12345678, rd, er, lat);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    xact(1'b1, 32'h400, 32'h12345678, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    xact(1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("rd0_data", rd, 32'h11111111);
    chk("rd0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("rd100_data", rd, 32'h22222222);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rd10_intact", rd, 32'hDEADBEEF);
    xact(1'b0, 32'h402, 32'h0, rd, er, lat);
    chk("rd_err_flag", 32'(er), 32'd1);
    chk("rd_err_rdata", rd, 32'd0);
    xact(1'b1, 32'h3FC, 32'hCAFEF00D, rd, er, lat);
    chk("top_wr_err", 32'(er), 32'd0);
    xact(1'b0, 32'h3FC, 32'h0, rd, er, lat);
    chk("top_rd_data", rd, 32'hCAFEF00D);

    // Request held high with different data while busy is ignored
    xact(1'b1, 32'h34, 32'h24680ACE, rd, er, lat);
    v_valid = 1'b1; v_we = 1'b1; v_addr = 32'h30; v_wdata = 32'h13579BDF; v_rsp_ready = 1'b1;
    step();
    v_addr = 32'h34; v_wdata = 32'hFFFFFFFF;
    chk("busy_ready0", 32'(o_req_ready), 32'd0);
    step();
    chk("busy_ready1", 32'(o_req_ready), 32'd0);
    step();
    chk("busy_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("busy_ready2", 32'(o_req_ready), 32'd0);
    v_valid = 1'b0;
    step();
    chk("busy_idle", 32'(o_req_ready), 32'd1);
    xact(1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("busy_first_done", rd, 32'h13579BDF);
    xact(1'b0, 32'h34, 32'h0, rd, er, lat);
    chk("busy_second_ignored", rd, 32'h24680ACE);

    // Reset together with req_valid: not accepted
    v_valid = 1'b1; v_we = 1'b1; v_addr = 32'h10; v_wdata = 32'h0;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0; v_valid = 1'b0;
    chk("rst_req_idle", 32'(o_req_ready), 32'd1);
    step();
    chk("rst_req_not_taken", 32'(o_req_ready), 32'd1);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rst_req_mem", rd, 32'hDEADBEEF);

    // Instance B, LATENCY=3: reset in WAIT and in RESP
    sel = 1'b1;
    xact(1'b1, 32'h20, 32'h01020304, rd, er, lat);
    chk("b_wr_lat", 32'(lat), 32'd3);
    v_valid = 1'b1; v_we = 1'b1; v_addr = 32'h20; v_wdata = 32'hAAAA5555; v_rsp_ready = 1'b1;
    step();
    v_valid = 1'b0;
    step();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("b_wait_rst_ready", 32'(o_req_ready), 32'd1);
    chk("b_wait_rst_valid", 32'(o_rsp_valid), 32'd0);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("b_wait_rst_data", rd, 32'h01020304);

    v_valid = 1'b1; v_we = 1'b1; v_addr = 32'h20; v_wdata = 32'hAAAA5555; v_rsp_ready = 1'b0;
    step();
    v_valid = 1'b0;
    step(); step(); step();
    chk("b_resp_valid", 32'(o_rsp_valid), 32'd1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("b_resp_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("b_resp_rst_ready", 32'(o_req_ready), 32'd1);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("b_resp_rst_data", rd, 32'hAAAA5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
